// File: rtl/exu_wb_arbiter.sv
// EXU writeback arbiter: merges ALU/MUL/MAC/DIV/LSU results onto the single register-file write port.
// Define EXU_WB_RR_EN to replace fixed priority (LSU>DIV>MUL>MAC>ALU) with round-robin.
module exu_wb_arbiter #(
   parameter int unsigned XLEN    = 32,
   parameter bit          DROP_X0 = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            alu_wb_valid,
   input  logic [4:0]      alu_wb_rd_addr,
   input  logic [XLEN-1:0] alu_wb_data,
   output logic            alu_wb_ready,
   input  logic            mul_wb_valid,
   input  logic [4:0]      mul_wb_rd_addr,
   input  logic [XLEN-1:0] mul_wb_data,
   output logic            mul_wb_ready,
   input  logic            mac_wb_valid,
   input  logic [4:0]      mac_wb_rd_addr,
   input  logic [XLEN-1:0] mac_wb_data,
   output logic            mac_wb_ready,
   input  logic            div_wb_valid,
   input  logic [4:0]      div_wb_rd_addr,
   input  logic [XLEN-1:0] div_wb_data,
   output logic            div_wb_ready,
   input  logic            lsu_wb_valid,
   input  logic [4:0]      lsu_wb_rd_addr,
   input  logic [XLEN-1:0] lsu_wb_data,
   output logic            lsu_wb_ready,
   output logic [XLEN-1:0] exu_wb_data,
   output logic [4:0]      exu_wb_rd_addr,
   output logic            exu_wb_rd_wr_en,
   output logic            exu_wb_pending
);

   localparam int unsigned NSRC = 5;

   // Index order doubles as the fixed-priority order and the round-robin rotation order.
   typedef enum logic [2:0] {
      SRC_LSU = 3'd0,
      SRC_DIV = 3'd1,
      SRC_MUL = 3'd2,
      SRC_MAC = 3'd3,
      SRC_ALU = 3'd4
   } src_e;

   logic [NSRC-1:0] in_v;
   logic [4:0]      in_rd   [NSRC];
   logic [XLEN-1:0] in_data [NSRC];

   logic [NSRC-1:0] hv_q, hv_d;
   logic [4:0]      hrd_q   [NSRC];
   logic [4:0]      hrd_d   [NSRC];
   logic [XLEN-1:0] hdata_q [NSRC];
   logic [XLEN-1:0] hdata_d [NSRC];

   logic [NSRC-1:0] keep_in;
   logic [NSRC-1:0] cand_v;
   logic [4:0]      cand_rd   [NSRC];
   logic [XLEN-1:0] cand_data [NSRC];

   logic            grant;
   logic [2:0]      win;

   logic            wen_q, wen_d;
   logic [4:0]      wrd_q, wrd_d;
   logic [XLEN-1:0] wdata_q, wdata_d;

   always_comb begin
      in_v             = '0;
      in_v[SRC_LSU]    = lsu_wb_valid;
      in_v[SRC_DIV]    = div_wb_valid;
      in_v[SRC_MUL]    = mul_wb_valid;
      in_v[SRC_MAC]    = mac_wb_valid;
      in_v[SRC_ALU]    = alu_wb_valid;
      in_rd[SRC_LSU]   = lsu_wb_rd_addr;
      in_rd[SRC_DIV]   = div_wb_rd_addr;
      in_rd[SRC_MUL]   = mul_wb_rd_addr;
      in_rd[SRC_MAC]   = mac_wb_rd_addr;
      in_rd[SRC_ALU]   = alu_wb_rd_addr;
      in_data[SRC_LSU] = lsu_wb_data;
      in_data[SRC_DIV] = div_wb_data;
      in_data[SRC_MUL] = mul_wb_data;
      in_data[SRC_MAC] = mac_wb_data;
      in_data[SRC_ALU] = alu_wb_data;
   end

   // An incoming result is only seen while its buffer is empty; x0 results vanish here.
   always_comb begin
      keep_in = '0;
      cand_v  = '0;
      for (int unsigned s = 0; s < NSRC; s++) begin
         keep_in[s]   = in_v[s] & ~hv_q[s] & ~(DROP_X0 & (in_rd[s] == 5'd0));
         cand_v[s]    = hv_q[s] | keep_in[s];
         cand_rd[s]   = hv_q[s] ? hrd_q[s]   : in_rd[s];
         cand_data[s] = hv_q[s] ? hdata_q[s] : in_data[s];
      end
   end

`ifdef EXU_WB_RR_EN
   src_e ptr_q, ptr_d;

   always_comb begin
      int unsigned idx;
      grant = 1'b0;
      win   = 3'd0;
      for (int unsigned k = 0; k < NSRC; k++) begin
         idx = 32'(ptr_q) + k;
         if (idx >= NSRC) idx = idx - NSRC;
         if (!grant && cand_v[idx]) begin
            grant = 1'b1;
            win   = 3'(idx);
         end
      end
      ptr_d = ptr_q;
      if (grant) ptr_d = (win == 3'(SRC_ALU)) ? SRC_LSU : src_e'(win + 3'd1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= SRC_LSU;
      else        ptr_q <= ptr_d;
   end
`else
   always_comb begin
      grant = 1'b0;
      win   = 3'd0;
      for (int unsigned s = 0; s < NSRC; s++) begin
         if (!grant && cand_v[s]) begin
            grant = 1'b1;
            win   = 3'(s);
         end
      end
   end
`endif

   // A granted buffer empties at the edge; a losing incoming result is parked at the same edge.
   always_comb begin
      hv_d = hv_q;
      for (int unsigned s = 0; s < NSRC; s++) begin
         hrd_d[s]   = hrd_q[s];
         hdata_d[s] = hdata_q[s];
         if (grant && (win == 3'(s))) begin
            hv_d[s] = 1'b0;
         end else if (keep_in[s]) begin
            hv_d[s]    = 1'b1;
            hrd_d[s]   = in_rd[s];
            hdata_d[s] = in_data[s];
         end
      end
      wen_d   = grant;
      wrd_d   = grant ? cand_rd[win]   : wrd_q;
      wdata_d = grant ? cand_data[win] : wdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hv_q    <= '0;
         wen_q   <= 1'b0;
         wrd_q   <= '0;
         wdata_q <= '0;
         for (int unsigned s = 0; s < NSRC; s++) begin
            hrd_q[s]   <= '0;
            hdata_q[s] <= '0;
         end
      end else begin
         hv_q    <= hv_d;
         wen_q   <= wen_d;
         wrd_q   <= wrd_d;
         wdata_q <= wdata_d;
         for (int unsigned s = 0; s < NSRC; s++) begin
            hrd_q[s]   <= hrd_d[s];
            hdata_q[s] <= hdata_d[s];
         end
      end
   end

   assign lsu_wb_ready    = ~hv_q[SRC_LSU];
   assign div_wb_ready    = ~hv_q[SRC_DIV];
   assign mul_wb_ready    = ~hv_q[SRC_MUL];
   assign mac_wb_ready    = ~hv_q[SRC_MAC];
   assign alu_wb_ready    = ~hv_q[SRC_ALU];
   assign exu_wb_rd_wr_en = wen_q;
   assign exu_wb_rd_addr  = wrd_q;
   assign exu_wb_data     = wdata_q;
   assign exu_wb_pending  = |hv_q;

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// Self-checking bench for exu_wb_arbiter: directed test-plan steps plus randomized traffic vs. a queue-free reference model.
module tb_exu_wb_arbiter;

   localparam int NS  = 5;
   localparam int LSU = 0;
   localparam int DIV = 1;
   localparam int MUL = 2;
   localparam int MAC = 3;
   localparam int ALU = 4;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        v   [NS];
   logic [4:0]  rd  [NS];
   logic [31:0] d   [NS];
   logic        rdy [NS];
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_wen;
   logic        wb_pend;

   always #5 clk = ~clk;

   exu_wb_arbiter #(.XLEN(32), .DROP_X0(1'b1)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .alu_wb_valid   (v[ALU]), .alu_wb_rd_addr(rd[ALU]), .alu_wb_data(d[ALU]), .alu_wb_ready(rdy[ALU]),
      .mul_wb_valid   (v[MUL]), .mul_wb_rd_addr(rd[MUL]), .mul_wb_data(d[MUL]), .mul_wb_ready(rdy[MUL]),
      .mac_wb_valid   (v[MAC]), .mac_wb_rd_addr(rd[MAC]), .mac_wb_data(d[MAC]), .mac_wb_ready(rdy[MAC]),
      .div_wb_valid   (v[DIV]), .div_wb_rd_addr(rd[DIV]), .div_wb_data(d[DIV]), .div_wb_ready(rdy[DIV]),
      .lsu_wb_valid   (v[LSU]), .lsu_wb_rd_addr(rd[LSU]), .lsu_wb_data(d[LSU]), .lsu_wb_ready(rdy[LSU]),
      .exu_wb_data    (wb_data),
      .exu_wb_rd_addr (wb_rd),
      .exu_wb_rd_wr_en(wb_wen),
      .exu_wb_pending (wb_pend)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: one parked result per source plus the expected write-port contents.
   bit          mhv [NS];
   logic [4:0]  mrd [NS];
   logic [31:0] md  [NS];
   int          mptr;
   bit          ewen;
   logic [4:0]  erd;
   logic [31:0] ed;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int s = 0; s < NS; s++) begin
         mhv[s] = 1'b0;
         mrd[s] = '0;
         md[s]  = '0;
      end
      mptr = LSU;
      ewen = 1'b0;
      erd  = '0;
      ed   = '0;
   endfunction

   function automatic void model_step();
      bit          cv [NS];
      logic [4:0]  cr [NS];
      logic [31:0] cd [NS];
      int          start;
      int          win;
      win = -1;
      for (int s = 0; s < NS; s++) begin
         cv[s] = 1'b0;
         cr[s] = '0;
         cd[s] = '0;
         if (mhv[s]) begin
            cv[s] = 1'b1; cr[s] = mrd[s]; cd[s] = md[s];
         end else if (v[s] && rd[s] != 5'd0) begin
            cv[s] = 1'b1; cr[s] = rd[s]; cd[s] = d[s];
         end
      end
`ifdef EXU_WB_RR_EN
      start = mptr;
`else
      start = LSU;
`endif
      for (int k = 0; k < NS; k++)
         if (win < 0 && cv[(start + k) % NS]) win = (start + k) % NS;
      for (int s = 0; s < NS; s++) begin
         if (mhv[s]) begin
            if (s == win) mhv[s] = 1'b0;
         end else if (v[s] && rd[s] != 5'd0 && s != win) begin
            mhv[s] = 1'b1; mrd[s] = rd[s]; md[s] = d[s];
         end
      end
      if (win >= 0) begin
         ewen = 1'b1; erd = cr[win]; ed = cd[win];
         mptr = (win + 1) % NS;
      end else begin
         ewen = 1'b0;
      end
   endfunction

   task automatic check_model();
      bit pend;
      pend = 1'b0;
      chk("wr_en", wb_wen, ewen);
      chk("rd", wb_rd, erd);
      chk("data", wb_data, ed);
      for (int s = 0; s < NS; s++) begin
         chk($sformatf("ready%0d", s), rdy[s], !mhv[s]);
         pend |= mhv[s];
      end
      chk("pending", wb_pend, pend);
      chk("no_x0_write", (wb_wen && wb_rd == 5'd0), 0);
   endtask

   task automatic clear_inputs();
      for (int s = 0; s < NS; s++) begin
         v[s] = 1'b0; rd[s] = '0; d[s] = '0;
      end
   endtask

   // Inputs set at a negedge; one posedge later, the next negedge compares DUT against model.
   task automatic tick();
      for (int s = 0; s < NS; s++)
         if (v[s]) begin
            assert (rdy[s] === 1'b1) else begin
               errors++;
               $error("FAIL protocol src%0d observed_ready=%0b expected_ready=1", s, rdy[s]);
            end
         end
      model_step();
      @(negedge clk);
      check_model();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      @(negedge clk);
      chk("rst_wr_en", wb_wen, 0);
      chk("rst_rd", wb_rd, 0);
      chk("rst_data", wb_data, 0);
      chk("rst_pending", wb_pend, 0);
      for (int s = 0; s < NS; s++) chk($sformatf("rst_ready%0d", s), rdy[s], 1);
      rst_n = 1'b1;
   endtask

   initial begin
      int          exp_seq [5];
      int          mac_sent;
      int          mac_w_loop;
      int          mac_w;
      clear_inputs();
      model_reset();
      do_reset();

      // Single ALU result
      v[ALU] = 1'b1; rd[ALU] = 5'd5; d[ALU] = 32'hDEADBEEF;
      tick();
      chk("t1_wen", wb_wen, 1);
      chk("t1_rd", wb_rd, 5);
      chk("t1_data", wb_data, 32'hDEADBEEF);
      chk("t1_alu_ready", rdy[ALU], 1);
      clear_inputs();
      tick();
      chk("t1_wen_off", wb_wen, 0);
      chk("t1_data_hold", wb_data, 32'hDEADBEEF);

      // ALU and MUL collide
      v[ALU] = 1'b1; rd[ALU] = 5'd3; d[ALU] = 32'h0000_00A3;
      v[MUL] = 1'b1; rd[MUL] = 5'd7; d[MUL] = 32'h0000_00B7;
      tick();
      chk("t2_rd_mul", wb_rd, 7);
      chk("t2_alu_ready", rdy[ALU], 0);
      chk("t2_pending", wb_pend, 1);
      clear_inputs();
      tick();
      chk("t2_rd_alu", wb_rd, 3);
      chk("t2_data_alu", wb_data, 32'h0000_00A3);
      tick();
      chk("t2_alu_ready_back", rdy[ALU], 1);
      chk("t2_pending_clr", wb_pend, 0);

      // All five at once
      do_reset();
      rd[ALU] = 5'd1; rd[MUL] = 5'd2; rd[MAC] = 5'd3; rd[DIV] = 5'd4; rd[LSU] = 5'd5;
      for (int s = 0; s < NS; s++) begin
         v[s] = 1'b1;
         d[s] = 32'h1111_1111 * rd[s];
      end
      exp_seq = '{5, 4, 2, 3, 1};
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 0) clear_inputs();
         chk($sformatf("t3_order%0d", i), wb_rd, exp_seq[i]);
         chk($sformatf("t3_wen%0d", i), wb_wen, 1);
      end
      tick();
      chk("t3_drained", wb_wen, 0);

      // x0 drop
      v[LSU] = 1'b1; rd[LSU] = 5'd0; d[LSU] = 32'h0000_1234;
      v[ALU] = 1'b1; rd[ALU] = 5'd9; d[ALU] = 32'h0000_0009;
      tick();
      chk("t4_rd", wb_rd, 9);
      chk("t4_lsu_ready", rdy[LSU], 1);
      clear_inputs();
      tick();
      chk("t4_wen_off", wb_wen, 0);

      // MAC stream against continuous LSU
      do_reset();
      mac_sent   = 0;
      mac_w_loop = 0;
      mac_w      = 0;
      for (int i = 0; i < 12; i++) begin
         clear_inputs();
         if (!mhv[LSU]) begin v[LSU] = 1'b1; rd[LSU] = 5'd20; d[LSU] = $urandom; end
         if (!mhv[MAC]) begin v[MAC] = 1'b1; rd[MAC] = 5'd10; d[MAC] = $urandom; mac_sent++; end
         tick();
         if (wb_wen && wb_rd == 5'd10) mac_w_loop++;
      end
      clear_inputs();
`ifdef EXU_WB_RR_EN
      chk("t5_rr_mac_writes", mac_w_loop, 6);
`else
      chk("t5_fixed_mac_starved", mac_w_loop, 0);
      chk("t5_fixed_mac_ready", rdy[MAC], 0);
`endif
      mac_w = mac_w_loop;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (wb_wen && wb_rd == 5'd10) mac_w++;
      end
      chk("t5_mac_scoreboard", mac_w, mac_sent);

      // Asynchronous reset with MUL parked
      do_reset();
      v[LSU] = 1'b1; rd[LSU] = 5'd4; d[LSU] = 32'h4444_0000;
      v[MUL] = 1'b1; rd[MUL] = 5'd6; d[MUL] = 32'h6666_0000;
      tick();
      chk("t6_pending", wb_pend, 1);
      chk("t6_mul_ready", rdy[MUL], 0);
      clear_inputs();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("t6_async_wen", wb_wen, 0);
      chk("t6_async_rd", wb_rd, 0);
      chk("t6_async_data", wb_data, 0);
      chk("t6_async_pending", wb_pend, 0);
      chk("t6_async_mul_ready", rdy[MUL], 1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_no_lost_write", wb_wen, 0);
      end

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         for (int s = 0; s < NS; s++) begin
            rd[s] = 5'($urandom_range(0, 31));
            d[s]  = $urandom;
            v[s]  = !mhv[s] && ($urandom_range(0, 2) == 0);
         end
         tick();
      end
      clear_inputs();
      for (int i = 0; i < 6; i++) tick();
      chk("rand_drained", wb_pend, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
